// File: rtl/rca_instr_encoder_pkg.sv
// Shared types for the RCA custom-instruction path: opcode, fn7/fn3 codes,
// instruction layout and the word encoder used by the issue-side encoder.
package rca_instr_encoder_pkg;

  typedef enum logic [6:0] {
    RCA_OPCODE = 7'b0101011
  } rca_opcode_t;

  typedef enum logic [6:0] {
    RCA_FN7 = 7'b1000000
  } rca_fn7_t;

  typedef enum logic [2:0] {
    RCA_USE_FB  = 3'b000,
    RCA_CFG_0   = 3'b001,
    RCA_CFG_1   = 3'b010,
    RCA_CFG_2   = 3'b011,
    RCA_CFG_3   = 3'b100,
    RCA_CFG_4   = 3'b101,
    RCA_USE_NFB = 3'b110
  } rca_fn3_t;

  localparam logic [2:0] RCA_FN3_ILLEGAL = 3'b111;

  typedef struct packed {
    logic [6:0] fn7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] fn3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } common_instruction_t;

  typedef common_instruction_t rca_instr_t;

  function automatic logic [31:0] encode_rca_instr(
    input logic [2:0] fn3,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    rca_instr_t w;
    w.fn7    = RCA_FN7;
    w.rs2    = rs2;
    w.rs1    = rs1;
    w.fn3    = fn3;
    w.rd     = rd;
    w.opcode = RCA_OPCODE;
    return w;
  endfunction

  // Register-stream increment: x31 wraps to x1 so x0 is never produced.
  function automatic logic [4:0] rca_next_rs1(input logic [4:0] cur);
    return (cur == 5'd31) ? 5'd1 : cur + 5'd1;
  endfunction

endpackage

// File: rtl/rca_instr_encoder_rs_cursor.sv
// rs1 cursor and remaining-word counter for one burst; loaded on request
// acceptance and advanced on every instruction handshake.
module rca_instr_encoder_rs_cursor
  import rca_instr_encoder_pkg::*;
#(
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [4:0]         base_i,
  input  logic [BURST_W-1:0] count_i,
  output logic [4:0]         rs1_o,
  output logic               last_o
);

  logic [4:0]         rs1_q, rs1_d;
  logic [BURST_W-1:0] rem_q, rem_d;

  always_comb begin
    rs1_d = rs1_q;
    rem_d = rem_q;
    if (load_i) begin
      rs1_d = base_i;
      rem_d = count_i;
    end else if (advance_i) begin
      rs1_d = rca_next_rs1(rs1_q);
      rem_d = rem_q - BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rs1_q <= '0;
      rem_q <= '0;
    end else begin
      rs1_q <= rs1_d;
      rem_q <= rem_d;
    end
  end

  assign rs1_o  = rs1_q;
  assign last_o = (rem_q == BURST_W'(1));

endmodule

// File: rtl/rca_instr_encoder.sv
// Expands RCA operation requests into bursts of 32-bit RCA custom
// instruction words with an auto-incrementing rs1, one word per cycle.
module rca_instr_encoder
  import rca_instr_encoder_pkg::*;
#(
  parameter  int MAX_BURST = 8,
  localparam int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_fn3,
  input  logic [4:0]         req_rd_addr,
  input  logic [4:0]         req_rs1_addr,
  input  logic [4:0]         req_rs2_addr,
  input  logic [BURST_W-1:0] req_count,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic               instr_last,
  output logic               req_error,
  output logic [31:0]        emitted_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  rca_fn3_t    fn3_q, fn3_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs2_q, rs2_d;
  logic        req_error_q, req_error_d;
  logic [31:0] emitted_count_q, emitted_count_d;

  logic        cur_load;
  logic        cur_advance;
  logic [4:0]  cur_rs1;
  logic        cur_last;
  logic        req_illegal;

  assign req_illegal = (req_fn3 == RCA_FN3_ILLEGAL)
                    || (req_count == '0)
                    || (req_count > BURST_W'(MAX_BURST));

  always_comb begin
    state_d         = state_q;
    fn3_d           = fn3_q;
    rd_d            = rd_q;
    rs2_d           = rs2_q;
    req_error_d     = 1'b0;
    emitted_count_d = emitted_count_q;
    cur_load        = 1'b0;
    cur_advance     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            req_error_d = 1'b1;
          end else begin
            fn3_d    = rca_fn3_t'(req_fn3);
            rd_d     = req_rd_addr;
            rs2_d    = req_rs2_addr;
            cur_load = 1'b1;
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        if (instr_ready) begin
          cur_advance     = 1'b1;
          emitted_count_d = emitted_count_q + 32'd1;
          if (cur_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      fn3_q           <= RCA_USE_FB;
      rd_q            <= '0;
      rs2_q           <= '0;
      req_error_q     <= 1'b0;
      emitted_count_q <= '0;
    end else begin
      state_q         <= state_d;
      fn3_q           <= fn3_d;
      rd_q            <= rd_d;
      rs2_q           <= rs2_d;
      req_error_q     <= req_error_d;
      emitted_count_q <= emitted_count_d;
    end
  end

  rca_instr_encoder_rs_cursor #(
    .BURST_W (BURST_W)
  ) u_rs_cursor (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cur_load),
    .advance_i (cur_advance),
    .base_i    (req_rs1_addr),
    .count_i   (req_count),
    .rs1_o     (cur_rs1),
    .last_o    (cur_last)
  );

  // Word fields all come from flops, so instr_ready never reaches instr.
  assign instr_valid   = (state_q == EMIT);
  assign instr         = instr_valid ? encode_rca_instr(fn3_q, rd_q, cur_rs1, rs2_q) : '0;
  assign instr_last    = instr_valid & cur_last;
  assign req_ready     = rst & (state_q == IDLE);
  assign req_error     = req_error_q;
  assign emitted_count = emitted_count_q;

endmodule

// File: tb/tb_rca_instr_encoder.sv
// Directed bench for rca_instr_encoder: single word, wrapping burst,
// backpressure, illegal requests, mid-burst reset and max-length burst.
module tb_rca_instr_encoder;

  localparam int MAX_BURST = 8;
  localparam int BURST_W   = $clog2(MAX_BURST + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_fn3;
  logic [4:0]         req_rd_addr;
  logic [4:0]         req_rs1_addr;
  logic [4:0]         req_rs2_addr;
  logic [BURST_W-1:0] req_count;
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic               instr_last;
  logic               req_error;
  logic [31:0]        emitted_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rca_instr_encoder #(.MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fn3       (req_fn3),
    .req_rd_addr   (req_rd_addr),
    .req_rs1_addr  (req_rs1_addr),
    .req_rs2_addr  (req_rs2_addr),
    .req_count     (req_count),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_last    (instr_last),
    .req_error     (req_error),
    .emitted_count (emitted_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [2:0] fn3, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [BURST_W-1:0] cnt);
    req_valid    = 1'b1;
    req_fn3      = fn3;
    req_rd_addr  = rd;
    req_rs1_addr = rs1;
    req_rs2_addr = rs2;
    req_count    = cnt;
    step();
    req_valid    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrap_rs1 [4];
    int max_rs1  [8];
    wrap_rs1 = '{30, 31, 1, 2};
    max_rs1  = '{28, 29, 30, 31, 1, 2, 3, 4};

    rst = 1'b0; req_valid = 1'b0; req_fn3 = '0; req_rd_addr = '0;
    req_rs1_addr = '0; req_rs2_addr = '0; req_count = '0; instr_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_last", 32'(instr_last), 32'd0);
    chk("rst_req_error", 32'(req_error), 32'd0);
    chk("rst_emitted", emitted_count, 32'd0);
    rst = 1'b1;
    step();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // single word
    instr_ready = 1'b1;
    request(3'b001, 5'd5, 5'd10, 5'd11, 4'd1);
    chk("single_valid", 32'(instr_valid), 32'd1);
    chk("single_instr", instr, 32'h80B5_12AB);
    chk("single_last", 32'(instr_last), 32'd1);
    chk("single_req_ready_busy", 32'(req_ready), 32'd0);
    step();
    chk("single_valid_drop", 32'(instr_valid), 32'd0);
    chk("single_emitted", emitted_count, 32'd1);
    chk("single_req_ready_back", 32'(req_ready), 32'd1);

    // burst wrapping rs1 past x31
    request(3'b010, 5'd3, 5'd30, 5'd7, 4'd4);
    chk("wrap_word0", instr, 32'h807F_21AB);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_valid%0d", i), 32'(instr_valid), 32'd1);
      chk($sformatf("wrap_rs1_%0d", i), 32'(instr[19:15]), 32'(wrap_rs1[i]));
      chk($sformatf("wrap_last%0d", i), 32'(instr_last), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("wrap_valid_drop", 32'(instr_valid), 32'd0);
    chk("wrap_emitted", emitted_count, 32'd5);

    // backpressure on word 2
    request(3'b100, 5'd1, 5'd4, 5'd2, 4'd3);
    chk("bp_w1_rs1", 32'(instr[19:15]), 32'd4);
    step();
    instr_ready = 1'b0;
    chk("bp_w2_instr", instr, 32'h8022_C0AB);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_valid%0d", i), 32'(instr_valid), 32'd1);
      chk($sformatf("bp_hold_instr%0d", i), instr, 32'h8022_C0AB);
      chk($sformatf("bp_hold_last%0d", i), 32'(instr_last), 32'd0);
    end
    chk("bp_hold_emitted", emitted_count, 32'd6);
    instr_ready = 1'b1;
    step();
    chk("bp_w3_rs1", 32'(instr[19:15]), 32'd6);
    chk("bp_w3_last", 32'(instr_last), 32'd1);
    step();
    chk("bp_valid_drop", 32'(instr_valid), 32'd0);
    chk("bp_emitted", emitted_count, 32'd8);

    // illegal requests
    request(3'b111, 5'd1, 5'd1, 5'd1, 4'd2);
    chk("ill_fn3_error", 32'(req_error), 32'd1);
    chk("ill_fn3_valid", 32'(instr_valid), 32'd0);
    step();
    chk("ill_fn3_error_pulse", 32'(req_error), 32'd0);
    chk("ill_fn3_valid2", 32'(instr_valid), 32'd0);
    request(3'b011, 5'd1, 5'd1, 5'd1, 4'd0);
    chk("ill_cnt0_error", 32'(req_error), 32'd1);
    chk("ill_cnt0_valid", 32'(instr_valid), 32'd0);
    step();
    chk("ill_cnt0_error_pulse", 32'(req_error), 32'd0);
    request(3'b011, 5'd1, 5'd1, 5'd1, 4'd9);
    chk("ill_cnt9_error", 32'(req_error), 32'd1);
    chk("ill_cnt9_valid", 32'(instr_valid), 32'd0);
    step();
    chk("ill_cnt9_error_pulse", 32'(req_error), 32'd0);
    chk("ill_cnt9_valid2", 32'(instr_valid), 32'd0);
    chk("ill_emitted", emitted_count, 32'd8);
    chk("ill_req_ready", 32'(req_ready), 32'd1);

    // reset in the middle of a burst
    request(3'b101, 5'd9, 5'd1, 5'd3, 4'd8);
    step(); step(); step();
    chk("mid_valid", 32'(instr_valid), 32'd1);
    chk("mid_emitted", emitted_count, 32'd11);
    chk("mid_rs1", 32'(instr[19:15]), 32'd4);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_emitted", emitted_count, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_idle_req_ready", 32'(req_ready), 32'd1);
    chk("mid_idle_valid", 32'(instr_valid), 32'd0);
    request(3'b000, 5'd0, 5'd0, 5'd0, 4'd1);
    chk("x0_instr", instr, 32'h8000_002B);
    chk("x0_last", 32'(instr_last), 32'd1);
    step();
    chk("x0_valid_drop", 32'(instr_valid), 32'd0);
    chk("x0_emitted", emitted_count, 32'd1);

    // maximum burst at full rate
    request(3'b110, 5'd31, 5'd28, 5'd4, 4'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("max_valid%0d", i), 32'(instr_valid), 32'd1);
      chk($sformatf("max_rs1_%0d", i), 32'(instr[19:15]), 32'(max_rs1[i]));
      chk($sformatf("max_last%0d", i), 32'(instr_last), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("max_req_ready%0d", i), 32'(req_ready), 32'd0);
      step();
    end
    chk("max_valid_drop", 32'(instr_valid), 32'd0);
    chk("max_req_ready_back", 32'(req_ready), 32'd1);
    chk("max_emitted", emitted_count, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
